// File: rtl/fft_tw_cmul_if.sv
// Sample/twiddle bus of the FFT twiddle multiplier: upstream stream, twiddle ROM port, downstream stream.
// The master side is the surrounding datapath (source, ROM, sink); the slave side is the multiplier.
interface fft_tw_cmul_if #(
  parameter int DW  = 9,
  parameter int TWW = 10
);
  logic                  din_valid;
  logic                  din_ready;
  logic                  din_first;
  logic signed [DW-1:0]  din_re;
  logic signed [DW-1:0]  din_im;
  logic [2:0]            tw_addr;
  logic signed [TWW-1:0] tw_re;
  logic signed [TWW-1:0] tw_im;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  dout_last;
  logic signed [DW-1:0]  dout_re;
  logic signed [DW-1:0]  dout_im;

  modport master (
    output din_valid, din_first, din_re, din_im, tw_re, tw_im, dout_ready,
    input  din_ready, tw_addr, dout_valid, dout_last, dout_re, dout_im
  );

  modport slave (
    input  din_valid, din_first, din_re, din_im, tw_re, tw_im, dout_ready,
    output din_ready, tw_addr, dout_valid, dout_last, dout_re, dout_im
  );
endinterface

// File: rtl/fft_tw_cmul.sv
// Streaming complex twiddle multiplier (3 register stages, valid/ready) for the 8-point FFT.
// Define TW_ROUND_EN to round half up before the >>8; otherwise the shift floors.
module fft_tw_cmul #(
  parameter int DW  = 9,
  parameter int TWW = 10
) (
  input logic           clk,
  input logic           rstn,
  fft_tw_cmul_if.slave  bus
);

  localparam int PW = DW + TWW;
  localparam int SW = PW + 1;
  localparam logic signed [SW-1:0] SAT_MAX = SW'((1 <<< (DW - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  logic                  stall;
  logic                  accept;
  logic [2:0]            addr;
  logic [2:0]            idx_q, idx_d;

  logic                  v1_q, last1_q;
  logic signed [DW-1:0]  re1_q, im1_q;
  logic signed [TWW-1:0] twRe1_q, twIm1_q;

  logic                  v2_q, last2_q;
  logic signed [PW-1:0]  pr_q, pi_q, pri_q, pir_q;
  logic signed [PW-1:0]  pr_d, pi_d, pri_d, pir_d;

  logic                  doutValid_q, doutLast_q;
  logic signed [DW-1:0]  doutRe_q, doutIm_q;
  logic signed [DW-1:0]  doutRe_d, doutIm_d;

  logic signed [SW-1:0]  reSum, imSum, reRnd, imRnd, reSh, imSh;

  function automatic logic signed [DW-1:0] saturate(input logic signed [SW-1:0] v);
    if (v > SAT_MAX)      saturate = SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) saturate = SAT_MIN[DW-1:0];
    else                  saturate = v[DW-1:0];
  endfunction

  // din_first forces address 0 so a frame can realign at any point without flagging an error.
  always_comb begin
    stall  = doutValid_q & ~bus.dout_ready;
    accept = bus.din_valid & ~stall;
    addr   = bus.din_first ? 3'd0 : idx_q;
    idx_d  = accept ? addr + 3'd1 : idx_q;
  end

  always_comb begin
    pr_d  = PW'(re1_q) * PW'(twRe1_q);
    pi_d  = PW'(im1_q) * PW'(twIm1_q);
    pri_d = PW'(re1_q) * PW'(twIm1_q);
    pir_d = PW'(im1_q) * PW'(twRe1_q);
  end

  // One extra bit absorbs the add/sub growth so saturation sees the true value.
  always_comb begin
    reSum = {pr_q[PW-1], pr_q} - {pi_q[PW-1], pi_q};
    imSum = {pri_q[PW-1], pri_q} + {pir_q[PW-1], pir_q};
`ifdef TW_ROUND_EN
    reRnd = reSum + SW'(128);
    imRnd = imSum + SW'(128);
`else
    reRnd = reSum;
    imRnd = imSum;
`endif
    reSh     = reRnd >>> 8;
    imSh     = imRnd >>> 8;
    doutRe_d = saturate(reSh);
    doutIm_d = saturate(imSh);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q       <= 3'd0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      re1_q       <= '0;
      im1_q       <= '0;
      twRe1_q     <= '0;
      twIm1_q     <= '0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      pr_q        <= '0;
      pi_q        <= '0;
      pri_q       <= '0;
      pir_q       <= '0;
      doutValid_q <= 1'b0;
      doutLast_q  <= 1'b0;
      doutRe_q    <= '0;
      doutIm_q    <= '0;
    end else begin
      idx_q <= idx_d;
      if (!stall) begin
        v1_q <= accept;
        if (accept) begin
          last1_q <= (addr == 3'd7);
          re1_q   <= bus.din_re;
          im1_q   <= bus.din_im;
          twRe1_q <= bus.tw_re;
          twIm1_q <= bus.tw_im;
        end
        v2_q    <= v1_q;
        last2_q <= last1_q;
        pr_q    <= pr_d;
        pi_q    <= pi_d;
        pri_q   <= pri_d;
        pir_q   <= pir_d;
        doutValid_q <= v2_q;
        doutLast_q  <= v2_q & last2_q;
        if (v2_q) begin
          doutRe_q <= doutRe_d;
          doutIm_q <= doutIm_d;
        end
      end
    end
  end

  assign bus.din_ready  = ~stall;
  assign bus.tw_addr    = addr;
  assign bus.dout_valid = doutValid_q;
  assign bus.dout_last  = doutLast_q;
  assign bus.dout_re    = doutRe_q;
  assign bus.dout_im    = doutIm_q;

endmodule

// File: tb/tb_fft_tw_cmul.sv
// Directed bench for fft_tw_cmul: reset, single-sample math, frame counter, backpressure, mid-stream reset.
// Rounding expectations follow the TW_ROUND_EN build macro.
module tb_fft_tw_cmul;

  logic clk;
  logic rstn;
  int   compareCount;
  int   mismatchCount;
  int   lastCount;
  int   s;
  int   expReQ[$];
  int   expImQ[$];
  bit   expLastQ[$];
  int   addrSeq[13];
  int   rndRe;

  fft_tw_cmul_if #(.DW(9), .TWW(10)) bus ();

  fft_tw_cmul #(.DW(9), .TWW(10)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic f, input int re, input int im,
                               input int twr, input int twi);
    bus.din_valid = v;
    bus.din_first = f;
    bus.din_re    = 9'(re);
    bus.din_im    = 9'(im);
    bus.tw_re     = 10'(twr);
    bus.tw_im     = 10'(twi);
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      mismatchCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pushExpected(input int re, input int im, input bit last);
    expReQ.push_back(re);
    expImQ.push_back(im);
    expLastQ.push_back(last);
  endtask

  // Any transfer the sink takes must match the oldest sample the bench sent.
  task automatic drainCheck(input string tag);
    if (bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      checkOutput({tag, "HasExpected"}, (expReQ.size() > 0) ? 1 : 0, 1);
      if (expReQ.size() > 0) begin
        checkOutput({tag, "Re"},   bus.dout_re,   expReQ[0]);
        checkOutput({tag, "Im"},   bus.dout_im,   expImQ[0]);
        checkOutput({tag, "Last"}, bus.dout_last, expLastQ[0]);
        if (bus.dout_last === 1'b1) lastCount++;
        void'(expReQ.pop_front());
        void'(expImQ.pop_front());
        void'(expLastQ.pop_front());
      end
    end
  endtask

  task automatic runSingle(input string tag, input int re, input int im, input int twr,
                           input int twi, input int expRe, input int expIm);
    applyStimulus(1'b1, 1'b1, re, im, twr, twi);
    step();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    step();
    checkOutput({tag, "NotYetValid"}, bus.dout_valid, 0);
    step();
    checkOutput({tag, "Valid"}, bus.dout_valid, 1);
    checkOutput({tag, "Re"},    bus.dout_re,    expRe);
    checkOutput({tag, "Im"},    bus.dout_im,    expIm);
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    lastCount     = 0;
    addrSeq = '{0, 1, 2, 0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
`ifdef TW_ROUND_EN
    rndRe = 71;
`else
    rndRe = 70;
`endif

    rstn = 1'b0;
    bus.dout_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    step();
    step();
    checkOutput("rstValid",   bus.dout_valid, 0);
    checkOutput("rstLast",    bus.dout_last,  0);
    checkOutput("rstRe",      bus.dout_re,    0);
    checkOutput("rstIm",      bus.dout_im,    0);
    checkOutput("rstTwAddr",  bus.tw_addr,    0);
    checkOutput("rstDinReady", bus.din_ready, 1);
    rstn = 1'b1;
    step();

    runSingle("identity", 100, -50, 256, 0, 100, -50);
    runSingle("quarter", 100, -50, 0, -256, -50, -100);
    runSingle("round", 100, 0, 181, -181, rndRe, -71);
    runSingle("saturate", -256, -256, 181, -181, -256, 0);
    step();

    // 13 back-to-back accepts, frame restarted on the 1st and 4th sample.
    s = 0;
    lastCount = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(s < 13, (s == 0) || (s == 3), s * 10, -s, 256, 0);
      #1;
      drainCheck("frame");
      if (s < 13) begin
        checkOutput($sformatf("frameTwAddr%0d", s), bus.tw_addr, addrSeq[s]);
        if (bus.din_ready === 1'b1) begin
          pushExpected(s * 10, -s, addrSeq[s] == 7);
          s++;
        end
      end
      step();
    end
    checkOutput("frameDrained",   expReQ.size(), 0);
    checkOutput("frameLastPulses", lastCount, 1);

    // Sink stalls for 5 cycles while the source keeps offering samples.
    s = 0;
    for (int c = 0; c < 25; c++) begin
      bus.dout_ready = !(c >= 4 && c < 9);
      applyStimulus(s < 8, s == 0, s * 17 - 60, 90 - s * 23, 256, 0);
      #1;
      if (c >= 4 && c < 9) begin
        checkOutput($sformatf("bpStallValid%0d", c), bus.dout_valid, 1);
        checkOutput($sformatf("bpStallReady%0d", c), bus.din_ready, 0);
        checkOutput($sformatf("bpHoldRe%0d", c), bus.dout_re, expReQ[0]);
        checkOutput($sformatf("bpHoldIm%0d", c), bus.dout_im, expImQ[0]);
      end
      drainCheck("bp");
      if (s < 8 && bus.din_ready === 1'b1) begin
        pushExpected(s * 17 - 60, 90 - s * 23, s == 7);
        s++;
      end
      step();
    end
    bus.dout_ready = 1'b1;
    checkOutput("bpAllSent",  s, 8);
    checkOutput("bpDrained",  expReQ.size(), 0);

    // Two samples in flight are flushed by a one-cycle reset.
    applyStimulus(1'b1, 1'b1, 33, 44, 256, 0);
    step();
    applyStimulus(1'b1, 1'b0, 55, 66, 256, 0);
    step();
    applyStimulus(1'b0, 1'b0, 0, 0, 0, 0);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    checkOutput("midRstValid",  bus.dout_valid, 0);
    checkOutput("midRstLast",   bus.dout_last,  0);
    checkOutput("midRstRe",     bus.dout_re,    0);
    checkOutput("midRstTwAddr", bus.tw_addr,    0);
    for (int c = 0; c < 5; c++) begin
      step();
      checkOutput($sformatf("midRstQuiet%0d", c), bus.dout_valid, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
